// File: rtl/block_xfer_seq_pkg.sv
// Shared HuC6280 types for the block-transfer sequencer: transfer modes and FSM states.
package hu6280_pkg;

    typedef enum logic [2:0] {
        TII = 3'd0,
        TDD = 3'd1,
        TIN = 3'd2,
        TIA = 3'd3,
        TAI = 3'd4
    } xfer_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } bx_state_t;

    localparam logic [16:0] LEN_FULL = 17'h10000;

    // A byte count of zero stands for the full 64 KiB space.
    function automatic logic [16:0] load_len(input logic [15:0] l);
        return (l == 16'd0) ? LEN_FULL : {1'b0, l};
    endfunction

endpackage

// File: rtl/block_xfer_seq_if.sv
// Core-request and MMU-bus signals of the block-transfer sequencer.
interface block_xfer_seq_if;
    import hu6280_pkg::*;

    logic        start;
    xfer_mode_t  mode;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [7:0]  bus_rdata;
    logic        MMU_stall;
    logic [15:0] VADDR;
    logic        RE;
    logic        WE;
    logic [7:0]  bus_wdata;
    logic        busy;
    logic        done;

    modport master (
        input  start, mode, src, dst, len, bus_rdata, MMU_stall,
        output VADDR, RE, WE, bus_wdata, busy, done
    );

    modport slave (
        output start, mode, src, dst, len, bus_rdata, MMU_stall,
        input  VADDR, RE, WE, bus_wdata, busy, done
    );

endinterface

// File: rtl/block_xfer_seq_addr_step.sv
// Per-mode pointer stepping and presented read/write addresses for block transfers.
module bx_addr_step
    import hu6280_pkg::*;
(
    input  xfer_mode_t  mode,
    input  logic [15:0] src_cur,
    input  logic [15:0] dst_cur,
    input  logic        alt,
    output logic [15:0] src_nxt,
    output logic [15:0] dst_nxt,
    output logic [15:0] rd_addr,
    output logic [15:0] wr_addr
);

    // Alternating sides keep their base pointer fixed and present base+alt.
    always_comb begin
        src_nxt = src_cur + 16'd1;
        dst_nxt = dst_cur + 16'd1;
        rd_addr = src_cur;
        wr_addr = dst_cur;
        case (mode)
            TDD: begin
                src_nxt = src_cur - 16'd1;
                dst_nxt = dst_cur - 16'd1;
            end
            TIN: dst_nxt = dst_cur;
            TIA: begin
                dst_nxt = dst_cur;
                wr_addr = dst_cur + {15'd0, alt};
            end
            TAI: begin
                src_nxt = src_cur;
                rd_addr = src_cur + {15'd0, alt};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/block_xfer_seq.sv
// HuC6280 block-transfer sequencer: owns the virtual bus and alternates MMU read/write
// cycles until the byte count is exhausted.
module block_xfer_seq
    import hu6280_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              RDY,
    block_xfer_seq_if.master  bx
);

    // state | meaning
    // IDLE  | bus released, waiting for start
    // READ  | read cycle at source address, latch data
    // WRITE | write cycle at destination address, step pointers
    // DONE  | one-cycle completion pulse

    bx_state_t   state_q, state_d;
    xfer_mode_t  mode_q, mode_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [16:0] rem_q, rem_d;
    logic        alt_q, alt_d;
    logic [7:0]  data_q, data_d;

    logic [15:0] src_nxt, dst_nxt, rd_addr, wr_addr;

    bx_addr_step u_addr_step (
        .mode    (mode_q),
        .src_cur (src_q),
        .dst_cur (dst_q),
        .alt     (alt_q),
        .src_nxt (src_nxt),
        .dst_nxt (dst_nxt),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= TII;
            src_q   <= 16'd0;
            dst_q   <= 16'd0;
            rem_q   <= 17'd0;
            alt_q   <= 1'b0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            alt_q   <= alt_d;
            data_q  <= data_d;
        end
    end

    // With RDY low every register simply reloads its own value.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        alt_d   = alt_q;
        data_d  = data_q;
        if (RDY) begin
            case (state_q)
                IDLE: begin
                    if (bx.start) begin
                        state_d = READ;
                        mode_d  = bx.mode;
                        src_d   = bx.src;
                        dst_d   = bx.dst;
                        rem_d   = load_len(bx.len);
                        alt_d   = 1'b0;
                    end
                end
                READ: begin
                    if (!bx.MMU_stall) begin
                        data_d  = bx.bus_rdata;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (!bx.MMU_stall) begin
                        src_d   = src_nxt;
                        dst_d   = dst_nxt;
                        rem_d   = rem_q - 17'd1;
                        alt_d   = ~alt_q;
                        state_d = (rem_q == 17'd1) ? DONE : READ;
                    end
                end
                DONE: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bx.VADDR     = 16'd0;
        bx.RE        = 1'b0;
        bx.WE        = 1'b0;
        bx.bus_wdata = 8'd0;
        bx.busy      = (state_q != IDLE);
        bx.done      = (state_q == DONE);
        case (state_q)
            READ: begin
                bx.VADDR = rd_addr;
                bx.RE    = 1'b1;
            end
            WRITE: begin
                bx.VADDR     = wr_addr;
                bx.WE        = 1'b1;
                bx.bus_wdata = data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_block_xfer_seq.sv
// Bench for block_xfer_seq: an access-list model of each transfer is compared with the bus
// every cycle, with directed transfers pinning addresses and latencies.
module tb_block_xfer_seq;
    import hu6280_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic RDY;

    block_xfer_seq_if bif();

    block_xfer_seq dut (
        .clk   (clk),
        .reset (reset),
        .RDY   (RDY),
        .bx    (bif.master)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'hA5;
    endfunction

    assign bif.bus_rdata = pat(bif.VADDR);

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    acc_t        exp_q[$];
    logic [15:0] obs_rd[$];
    logic [15:0] obs_wr[$];
    bit          pend_done;
    bit          model_active;
    bit          armed;
    bit          done_seen;
    int          cyc;
    int          start_cyc;
    int          done_cyc;
    int          vectors;
    int          miscompares;
    int          stim_mode;
    int          freeze_cnt;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic fail_now(string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endtask

    // Full expected access list of a transfer, straight from the per-mode address rules.
    task automatic build(xfer_mode_t m, logic [15:0] s, logic [15:0] d, logic [15:0] l);
        int          n;
        logic [15:0] ra, wa, iv;
        n = (l == 16'd0) ? 65536 : int'(l);
        exp_q.delete();
        obs_rd.delete();
        obs_wr.delete();
        for (int i = 0; i < n; i++) begin
            iv = 16'(i);
            case (m)
                TDD: begin ra = s - iv; wa = d - iv; end
                TIN: begin ra = s + iv; wa = d; end
                TIA: begin ra = s + iv; wa = d + {15'd0, iv[0]}; end
                TAI: begin ra = s + {15'd0, iv[0]}; wa = d + iv; end
                default: begin ra = s + iv; wa = d + iv; end
            endcase
            exp_q.push_back('{1'b0, ra, 8'h00});
            exp_q.push_back('{1'b1, wa, pat(ra)});
        end
    endtask

    task automatic compare_step();
        acc_t       e;
        logic [3:0] want;
        cyc++;
        if (!armed) return;
        want = 4'b0000;
        e = '{1'b0, 16'h0, 8'h0};
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            want = e.wr ? 4'b0110 : 4'b1010;
            chk("vaddr", 32'(bif.VADDR), 32'(e.addr));
            if (e.wr) chk("wdata", 32'(bif.bus_wdata), 32'(e.data));
        end else if (pend_done) begin
            want = 4'b0011;
        end
        chk("re_we_busy_done", 32'({bif.RE, bif.WE, bif.busy, bif.done}), 32'(want));
        if (bif.done) begin
            done_seen = 1'b1;
            done_cyc = cyc;
        end
        if (reset) begin
            exp_q.delete();
            pend_done = 1'b0;
        end else if (RDY) begin
            if (exp_q.size() > 0) begin
                if (!bif.MMU_stall) begin
                    if (e.wr) obs_wr.push_back(e.addr);
                    else obs_rd.push_back(e.addr);
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) pend_done = 1'b1;
                end
            end else if (pend_done) begin
                pend_done = 1'b0;
            end else if (bif.start) begin
                build(bif.mode, bif.src, bif.dst, bif.len);
                start_cyc = cyc;
                done_seen = 1'b0;
            end
        end
        model_active = (exp_q.size() > 0) || pend_done;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_step();
        @(posedge clk);
        #1;
        case (stim_mode)
            1: begin
                RDY = ($urandom_range(0, 3) != 0);
                bif.MMU_stall = ($urandom_range(0, 2) == 0);
            end
            2: begin
                RDY = 1'b1;
                bif.MMU_stall = bif.WE && !bif.MMU_stall;
            end
            default: begin
                RDY = 1'b1;
                bif.MMU_stall = 1'b0;
            end
        endcase
        if (freeze_cnt > 0) begin
            RDY = 1'b0;
            freeze_cnt--;
        end
    endtask

    // Raises start and leaves it high until the model has seen it accepted.
    task automatic start_xfer(xfer_mode_t m, logic [15:0] s, logic [15:0] d, logic [15:0] l);
        int n;
        bif.mode  = m;
        bif.src   = s;
        bif.dst   = d;
        bif.len   = l;
        bif.start = 1'b1;
        n = 0;
        while (!model_active && n < 200) begin
            tick();
            n++;
        end
        if (!model_active) fail_now("accept_timeout");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (model_active && n < 5000) begin
            tick();
            n++;
        end
        if (model_active) fail_now("idle_timeout");
    endtask

    task automatic run_xfer(xfer_mode_t m, logic [15:0] s, logic [15:0] d, logic [15:0] l);
        start_xfer(m, s, d, l);
        bif.start = 1'b0;
        wait_idle();
        tick();
    endtask

    task automatic chk_seq(string nm, bit wr, int n,
                           logic [15:0] e0, logic [15:0] e1, logic [15:0] e2, logic [15:0] e3);
        logic [15:0] ex[4];
        ex = '{e0, e1, e2, e3};
        if (wr) begin
            chk({nm, "_count"}, 32'(obs_wr.size()), 32'(n));
            for (int i = 0; i < n && i < obs_wr.size(); i++) chk(nm, 32'(obs_wr[i]), 32'(ex[i]));
        end else begin
            chk({nm, "_count"}, 32'(obs_rd.size()), 32'(n));
            for (int i = 0; i < n && i < obs_rd.size(); i++) chk(nm, 32'(obs_rd[i]), 32'(ex[i]));
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        RDY = 1'b1;
        bif.start = 1'b0;
        bif.mode = TII;
        bif.src = 16'h0;
        bif.dst = 16'h0;
        bif.len = 16'h0;
        bif.MMU_stall = 1'b0;
        stim_mode = 0;
        freeze_cnt = 0;
        armed = 1'b0;
        pend_done = 1'b0;
        model_active = 1'b0;
        done_seen = 1'b0;
        cyc = 0;
        start_cyc = 0;
        done_cyc = -1;
        vectors = 0;
        miscompares = 0;

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_ctl", 32'({bif.RE, bif.WE, bif.busy, bif.done}), 32'h0);
        chk("reset_vaddr", 32'(bif.VADDR), 32'h0);
        chk("reset_wdata", 32'(bif.bus_wdata), 32'h0);
        armed = 1'b1;
        reset = 1'b0;
        tick();
        tick();

        run_xfer(TII, 16'h2000, 16'h3000, 16'd3);
        chk_seq("tii_rd", 1'b0, 3, 16'h2000, 16'h2001, 16'h2002, 16'h0);
        chk_seq("tii_wr", 1'b1, 3, 16'h3000, 16'h3001, 16'h3002, 16'h0);
        chk("tii_done_latency", 32'(done_cyc - start_cyc), 32'd7);

        run_xfer(TDD, 16'h0001, 16'h4001, 16'd3);
        chk_seq("tdd_rd", 1'b0, 3, 16'h0001, 16'h0000, 16'hFFFF, 16'h0);
        chk_seq("tdd_wr", 1'b1, 3, 16'h4001, 16'h4000, 16'h3FFF, 16'h0);

        run_xfer(TIA, 16'h2000, 16'h0402, 16'd4);
        chk_seq("tia_wr", 1'b1, 4, 16'h0402, 16'h0403, 16'h0402, 16'h0403);

        run_xfer(TAI, 16'h0402, 16'h2000, 16'd4);
        chk_seq("tai_rd", 1'b0, 4, 16'h0402, 16'h0403, 16'h0402, 16'h0403);

        stim_mode = 2;
        run_xfer(TIN, 16'h1000, 16'h5000, 16'd3);
        chk_seq("tin_wr", 1'b1, 3, 16'h5000, 16'h5000, 16'h5000, 16'h0);
        chk("tin_stall_latency", 32'(done_cyc - start_cyc), 32'd10);
        stim_mode = 0;
        tick();

        // RDY drops on the first READ and stays low for five cycles.
        start_xfer(TII, 16'h2000, 16'h3000, 16'd3);
        bif.start = 1'b0;
        RDY = 1'b0;
        freeze_cnt = 4;
        wait_idle();
        tick();
        chk_seq("freeze_rd", 1'b0, 3, 16'h2000, 16'h2001, 16'h2002, 16'h0);
        chk("freeze_latency", 32'(done_cyc - start_cyc), 32'd12);

        run_xfer(TII, 16'hFFFF, 16'h0010, 16'd1);
        chk_seq("len1_wr", 1'b1, 1, 16'h0010, 16'h0, 16'h0, 16'h0);
        chk("len1_latency", 32'(done_cyc - start_cyc), 32'd3);

        // start held high through the whole transfer, including the DONE cycle.
        start_xfer(TII, 16'h0100, 16'h0200, 16'd2);
        wait_idle();
        bif.start = 1'b0;
        tick();
        tick();
        chk("busy_start_ignored", 32'(bif.busy), 32'h0);
        chk("busy_start_latency", 32'(done_cyc - start_cyc), 32'd5);

        start_xfer(TII, 16'h8000, 16'hC000, 16'd0);
        bif.start = 1'b0;
        chk("len0_remaining", 32'(dut.rem_q), 32'h10000);
        repeat (1500) tick();
        n = 0;
        while (!bif.WE && n < 10) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_idle", 32'({bif.RE, bif.WE, bif.busy, bif.done}), 32'h0);
        tick();
        chk("abort_no_done", 32'(done_seen), 32'h0);
        chk("len0_progress", 32'(obs_wr.size() >= 700), 32'h1);

        stim_mode = 1;
        for (int t = 0; t < 40; t++) begin
            run_xfer(xfer_mode_t'(3'($urandom_range(0, 4))), 16'($urandom), 16'($urandom),
                     16'($urandom_range(1, 24)));
        end
        stim_mode = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
